// File: rtl/i2c_target_regfile.sv
// I2C target responder: 7-bit addressed device mapped onto a register bus
// with an auto-incrementing register pointer. Never stretches SCL.
module i2c_target_regfile #(
    parameter int FILT_CNT = 4,
    parameter int PTR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [6:0]       slv_adr,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             reg_wr,
    output logic             reg_rd,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wdata,
    input  logic [7:0]       reg_rdata,
    output logic             busy,
    output logic             xfer_done
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [3:0] FILT_M1 = 4'(FILT_CNT - 1);

    // Line index 0 = SCL, 1 = SDA.
    logic [1:0] meta, sync, filt, prev;
    logic [3:0] cnt [2];

    logic scl_rise, scl_fall, start_det, stop_det;

    state_t           state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             ack_q, ack_d;
    logic             oe_d, wr_d, rd_d, busy_d, done_d;
    logic [PTR_W-1:0] addr_d;
    logic [7:0]       wdata_d;
    logic [7:0]       rx_byte;

    // Synchronize both pad inputs, then require FILT_CNT stable cycles before the filtered level moves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta   <= '1;
            sync   <= '1;
            filt   <= '1;
            prev   <= '1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            meta <= {sda_i, scl_i};
            sync <= meta;
            prev <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == FILT_M1) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise  =  filt[0] & ~prev[0];
    assign scl_fall  = ~filt[0] &  prev[0];
    assign start_det =  filt[0] &  prev[0] &  prev[1] & ~filt[1];
    assign stop_det  =  filt[0] &  prev[0] & ~prev[1] &  filt[1];
    assign rx_byte   = {shift_q[6:0], filt[1]};

    // Protocol state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            sda_oe    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            sda_oe    <= oe_d;
            reg_wr    <= wr_d;
            reg_rd    <= rd_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            busy      <= busy_d;
            xfer_done <= done_d;
        end
    end

    // Next-state and output decode; START/STOP take priority over bit-level events.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        ack_d   = ack_q;
        oe_d    = sda_oe;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = reg_addr;
        wdata_d = reg_wdata;
        busy_d  = busy;
        done_d  = 1'b0;

        // Read data is valid the cycle after the strobe.
        if (reg_rd) tx_d = reg_rdata;

        if (!en) begin
            state_d = IDLE;
            bit_d   = '0;
            ptr_d   = '0;
            ack_d   = 1'b0;
            oe_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            bit_d   = '0;
            ack_d   = 1'b0;
            oe_d    = 1'b0;
            done_d  = busy;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            bit_d   = '0;
            ack_d   = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (rx_byte[7:1] == slv_adr && rx_byte[7:1] != 7'd0) begin
                            state_d = ADDR_ACK;
                            rw_d    = rx_byte[0];
                            if (rx_byte[0]) begin
                                rd_d   = 1'b1;
                                addr_d = ptr_q;
                            end
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                // First fall drives ACK; second fall ends it (sda_oe doubles as the phase flag).
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_d   = 1'b1;
                        busy_d = 1'b1;
                    end else begin
                        oe_d  = 1'b0;
                        bit_d = '0;
                        if (state_q == ADDR_ACK) begin
                            if (rw_q) begin
                                oe_d    = ~tx_q[7];
                                state_d = RDATA;
                            end else begin
                                state_d = PTR;
                            end
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        ptr_d   = PTR_W'(rx_byte);
                        state_d = PTR_ACK;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        wr_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = rx_byte;
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = WDATA_ACK;
                    end
                end
                RDATA: if (scl_fall) begin
                    if (bit_q == 3'd7) begin
                        oe_d    = 1'b0;
                        ptr_d   = ptr_q + PTR_W'(1);
                        ack_d   = 1'b0;
                        state_d = RDATA_ACK;
                    end else begin
                        oe_d  = ~tx_q[6];
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                    end
                end
                // ack_q marks that the master ACKed and the next byte is being fetched.
                RDATA_ACK: begin
                    if (scl_rise && !ack_q) begin
                        if (filt[1]) begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end else begin
                            rd_d   = 1'b1;
                            addr_d = ptr_q;
                            ack_d  = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        oe_d    = ~tx_q[7];
                        bit_d   = '0;
                        ack_d   = 1'b0;
                        state_d = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
